esc_pwm_quad: RTL and testbench
===============================

Name: esc_pwm_quad

Overview:
Receiver end of the flight-controller motor-speed interface. It takes the four 11-bit unsigned motor speeds (front, back, left, right) and produces four ESC servo-style PWM outputs on a common frame period. New speeds are double-buffered and applied only at frame boundaries, so no pulse is ever glitched. An arming state machine holds the ESCs at minimum pulse for a set number of frames before accepting commanded speeds.

Parameters:
PERIOD, 20'd1_000_000, frame length in clk cycles (20 ms at 50 MHz); range 2..2^20.
MIN_PULSE, 17'd50000, pulse width in clocks for speed 0 (1 ms).
SPD_GAIN, 5'd24, clocks of pulse width per speed LSB.
ARM_PERIODS, 4'd8, number of minimum-pulse frames in ARMING; must be at least 1.
Constraint: MIN_PULSE + 2047*SPD_GAIN < PERIOD. The defaults give 99128 < 1_000_000.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frnt_spd  in  11  front motor speed, unsigned
bck_spd  in  11  back motor speed, unsigned
lft_spd  in  11  left motor speed, unsigned
rght_spd  in  11  right motor speed, unsigned
spd_vld  in  1  the four speed inputs are valid this cycle
en  in  1  motor enable level
spd_ack  out  1  one-cycle pulse confirming a speed capture
frnt_pwm  out  1  front ESC pulse
bck_pwm  out  1  back ESC pulse
lft_pwm  out  1  left ESC pulse
rght_pwm  out  1  right ESC pulse
frame_start  out  1  high in the cycle where cnt==0
armed  out  1  high in RUN state

Behaviour:
- One clock domain; all logic is synchronous to clk.
- Reset (rst=1 on a clk edge):
  - cnt=0; state=DISARMED.
  - Pending and active speed registers = 0; pend flag = 0.
  - All pwm outputs, armed, frame_start and spd_ack = 0.
  - Reset takes effect on that edge regardless of state, including mid-pulse.
- Frame counter cnt (20 bit):
  - Increments each clock and wraps PERIOD-1 -> 0.
  - "Boundary" is the edge where cnt goes PERIOD-1 -> 0.
  - frame_start is registered and equals (cnt==0).
- Capture:
  - Any cycle with spd_vld=1 loads all four inputs into the pending registers and sets pend.
  - spd_ack=1 in the following cycle only.
  - Back-to-back spd_vld: the last value wins; spd_ack pulses for each capture.
- Apply at boundary:
  - If spd_vld=1 on the boundary cycle, the active registers take the inputs directly (bypass) and pend clears.
  - Else if pend=1, active takes pending and pend clears.
  - Otherwise active holds.
- Width calculation:
  - width_x = MIN_PULSE + active_x*SPD_GAIN, unsigned, 17 bits.
  - width_x is registered in the cycle after the active update.
  - The compare therefore uses the new width from cnt==1 onward; cnt==0 always drives high.
- PWM flops:
  - At the boundary edge, pwm_x <= 1 if the state after the boundary is ARMING or RUN, else 0.
  - At the edge where cnt becomes width (ARMING uses MIN_PULSE), pwm_x <= 0.
  - Result: each enabled pulse is high for exactly width clocks, starting in the cycle where cnt==0.
- State machine. All transitions are evaluated only at the boundary, which avoids runt pulses.
  - DISARMED:
    - No pulses.
    - At the boundary with en=1 -> ARMING, with arm_cnt=0.
  - ARMING:
    - All four outputs use MIN_PULSE; speeds are still captured and applied to the active registers.
    - arm_cnt increments at each boundary.
    - At the boundary where arm_cnt==ARM_PERIODS -> RUN. This gives exactly ARM_PERIODS minimum pulses.
    - en=0 at a boundary -> DISARMED.
  - RUN:
    - Outputs use width_x; armed=1 (registered, set at the boundary entering RUN).
    - en=0 at a boundary -> DISARMED; armed clears at that edge.
- en changes mid-frame: the pulse in progress completes normally.
- spd_vld in DISARMED: still captured. It is applied at the next boundary but not visible until RUN.

Test Plan:
Bench overrides: PERIOD=4096, MIN_PULSE=1000, SPD_GAIN=1, ARM_PERIODS=2.
1. rst held 3 cycles, then en=0 for 2 frames -> all outputs 0 during reset; afterwards frame_start pulses every 4096 clocks and no pwm pulses occur.
2. en=1 raised at cnt=100 -> first pulse starts at the next cnt==0. Two frames of 1000-clock pulses on all four outputs, and armed=1 from the third boundary.
3. In RUN, spd_vld at cnt=2000 with frnt=0x7FF, bck=0, lft=100, rght=1000 -> spd_ack high at cnt=2001. The current frame is unchanged; the next frame has widths 3047, 1000, 1100 and 2000 clocks.
4. spd_vld with frnt=500 on the cycle cnt==4095 -> the frame starting next cycle has a front pulse of exactly 1500 clocks.
5. In RUN, en=0 at cnt=500 with width 2000 -> the current pulse ends at 2000. At the next boundary armed=0 and no pulse follows. Re-asserting en repeats the 2-frame ARMING sequence.
6. rst=1 at cnt=300 during a pulse -> the next cycle has pwm=0, cnt=0, armed=0, state DISARMED, and the active speeds cleared.

Source files
------------

// File: rtl/esc_pwm_quad.sv
`default_nettype none
// ============================================================================
// esc_pwm_quad : four-channel ESC PWM generator with frame-aligned speed update
//                and an arming sequence of minimum-width frames.
// Revision     : 1.0
// ============================================================================
module esc_pwm_quad #(
  parameter logic [20:0] PERIOD      = 21'd1_000_000,
  parameter logic [16:0] MIN_PULSE   = 17'd50000,
  parameter logic [4:0]  SPD_GAIN    = 5'd24,
  parameter logic [3:0]  ARM_PERIODS = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        spd_vld,
  input  logic        en,
  output logic        spd_ack,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frame_start,
  output logic        armed
);

  localparam logic [19:0] c_cnt_last = 20'(PERIOD - 21'd1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [19:0]        cnt_q, cnt_d;
  logic [3:0]         arm_cnt_q, arm_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic               spd_ack_q, spd_ack_d;
  logic               armed_q, armed_d;
  logic               pend_q, pend_d;
  logic [3:0][10:0]   pend_spd_q, pend_spd_d;
  logic [3:0][10:0]   act_spd_q, act_spd_d;
  logic [3:0][16:0]   width_q, width_d;
  logic [3:0]         pwm_q, pwm_d;

  logic               boundary;
  logic [3:0][10:0]   spd_in;
  logic [16:0]        pulse_len;

  // Channel order throughout: 0 front, 1 back, 2 left, 3 right.
  assign spd_in = {rght_spd, lft_spd, bck_spd, frnt_spd};

  always_comb begin
    boundary      = (cnt_q == c_cnt_last);
    cnt_d         = boundary ? 20'd0 : cnt_q + 20'd1;
    frame_start_d = (cnt_d == 20'd0);
    spd_ack_d     = spd_vld;
    pend_spd_d    = spd_vld ? spd_in : pend_spd_q;
    pend_d        = pend_q;
    act_spd_d     = act_spd_q;

    // A capture landing on the boundary cycle bypasses the pending buffer.
    if (boundary) begin
      if (spd_vld) begin
        act_spd_d = spd_in;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        act_spd_d = pend_spd_q;
        pend_d    = 1'b0;
      end
    end else if (spd_vld) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (boundary) begin
      case (state_q)
        ST_DISARMED: begin
          if (en) begin
            state_d   = ST_ARMING;
            arm_cnt_d = 4'd0;
          end
        end
        ST_ARMING: begin
          arm_cnt_d = arm_cnt_q + 4'd1;
          if (!en) begin
            state_d = ST_DISARMED;
          end else if (({1'b0, arm_cnt_q} + 5'd1) == {1'b0, ARM_PERIODS}) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d = ST_DISARMED;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
    armed_d = (state_d == ST_RUN);
  end

  always_comb begin
    pulse_len = MIN_PULSE;
    width_d   = width_q;
    pwm_d     = pwm_q;
    for (int i = 0; i < 4; i++) begin
      width_d[i] = MIN_PULSE + 17'(act_spd_q[i]) * 17'(SPD_GAIN);
      pulse_len  = (state_q == ST_RUN) ? width_q[i] : MIN_PULSE;
      if (boundary) begin
        pwm_d[i] = (state_d != ST_DISARMED);
      end else if ((cnt_q + 20'd1) == {3'b000, pulse_len}) begin
        pwm_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DISARMED;
      cnt_q         <= 20'd0;
      arm_cnt_q     <= 4'd0;
      frame_start_q <= 1'b0;
      spd_ack_q     <= 1'b0;
      armed_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_spd_q    <= '0;
      act_spd_q     <= '0;
      width_q       <= '0;
      pwm_q         <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      arm_cnt_q     <= arm_cnt_d;
      frame_start_q <= frame_start_d;
      spd_ack_q     <= spd_ack_d;
      armed_q       <= armed_d;
      pend_q        <= pend_d;
      pend_spd_q    <= pend_spd_d;
      act_spd_q     <= act_spd_d;
      width_q       <= width_d;
      pwm_q         <= pwm_d;
    end
  end

  assign spd_ack     = spd_ack_q;
  assign frame_start = frame_start_q;
  assign armed       = armed_q;
  assign frnt_pwm    = pwm_q[0];
  assign bck_pwm     = pwm_q[1];
  assign lft_pwm     = pwm_q[2];
  assign rght_pwm    = pwm_q[3];

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_quad.sv
`default_nettype none
// ============================================================================
// tb_esc_pwm_quad : scoreboard bench; per-frame pulse widths and ack timing.
// Revision        : 1.0
// ============================================================================
module tb_esc_pwm_quad;

  localparam int P = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        spd_vld = 1'b0;
  logic [10:0] frnt_spd = 11'd0, bck_spd = 11'd0, lft_spd = 11'd0, rght_spd = 11'd0;
  logic        spd_ack, frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_start, armed;

  esc_pwm_quad #(
    .PERIOD(21'd4096), .MIN_PULSE(17'd1000), .SPD_GAIN(5'd1), .ARM_PERIODS(4'd2)
  ) dut (
    .clk(clk), .rst(rst),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .en(en), .spd_ack(spd_ack),
    .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
    .frame_start(frame_start), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] w;
    logic             armed;
  } frame_t;

  frame_t frame_q[$];
  int     ack_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     tb_cnt = 0;
  bit     rst_seen = 1'b0;
  bit     done = 1'b0;
  int     hi[4];
  bit     first[4];
  bit     arm_s = 1'b0;
  bit     in_frame = 1'b0;
  int     frame_no = 0;
  logic [3:0] pwm;

  assign pwm = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};

  // Reference frame position, independent of the DUT.
  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s frame=%0d cnt=%0d actual=%0d expected=%0d",
               name, frame_no, tb_cnt, act, exp);
    end
  endtask

  task automatic open_frame();
    for (int i = 0; i < 4; i++) begin
      hi[i]    = 0;
      first[i] = pwm[i];
    end
    arm_s    = 1'b0;
    in_frame = 1'b1;
  endtask

  task automatic close_frame();
    frame_t e;
    if (frame_q.size() == 0) begin
      chk("frame_expectation_missing", 1, 0);
    end else begin
      e = frame_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("width_ch%0d", i), hi[i], int'(e.w[i]));
        chk($sformatf("start_ch%0d", i), int'(first[i]), int'(e.w[i] != 16'd0));
      end
      chk("armed", int'(arm_s), int'(e.armed));
    end
    frame_no++;
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_outputs", int'({pwm, armed, frame_start, spd_ack}), 0);
      open_frame();
    end else begin
      if (tb_cnt == 0) begin
        if (in_frame) close_frame();
        open_frame();
        chk("frame_start", int'(frame_start), 1);
      end else if (frame_start) begin
        chk("frame_start_spurious", 1, 0);
      end
      for (int i = 0; i < 4; i++) if (pwm[i]) hi[i]++;
      if (tb_cnt == 1) arm_s = armed;
      if (spd_ack) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 1, 0);
        else                   chk("ack_cnt", tb_cnt, ack_q.pop_front());
      end
    end
    if (done) begin
      chk("frames_left", frame_q.size(), 0);
      chk("acks_left", ack_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int n);
    int k = 0;
    while (tb_cnt != n && k < 2 * P) begin
      tick();
      k++;
    end
    if (tb_cnt != n) begin
      $display("FAIL wait_cnt actual=%0d expected=%0d", tb_cnt, n);
      $fatal(1, "frame position wait expired");
    end
  endtask

  task automatic next_frame();
    tick();
    wait_cnt(0);
  endtask

  task automatic push_frame(input int w0, input int w1, input int w2, input int w3,
                            input bit a);
    frame_t f;
    f.w[0]  = 16'(w0);
    f.w[1]  = 16'(w1);
    f.w[2]  = 16'(w2);
    f.w[3]  = 16'(w3);
    f.armed = a;
    frame_q.push_back(f);
  endtask

  task automatic send_spd(input int f, input int b, input int l, input int r);
    frnt_spd = 11'(f);
    bck_spd  = 11'(b);
    lft_spd  = 11'(l);
    rght_spd = 11'(r);
    spd_vld  = 1'b1;
    ack_q.push_back((tb_cnt + 1) % P);
    tick();
    spd_vld  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Disabled: two frames with no pulses.
    push_frame(0, 0, 0, 0, 1'b0);
    next_frame(); push_frame(0, 0, 0, 0, 1'b0);

    // Enable mid-frame; two arming frames, then RUN.
    next_frame(); push_frame(0, 0, 0, 0, 1'b0);
    wait_cnt(100); en = 1'b1;
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b1);

    // Mid-frame capture applies at the next boundary only.
    wait_cnt(2000); send_spd(2047, 0, 100, 1000);
    next_frame(); push_frame(3047, 1000, 1100, 2000, 1'b1);

    // Capture on the last cycle of the frame bypasses into the next frame.
    wait_cnt(P - 1); send_spd(500, 0, 100, 1000);
    push_frame(1500, 1000, 1100, 2000, 1'b1);

    // Disable mid-pulse: pulse completes, then disarmed frame.
    wait_cnt(500); en = 1'b0;
    next_frame(); push_frame(0, 0, 0, 0, 1'b0);
    wait_cnt(100); en = 1'b1;
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1500, 1000, 1100, 2000, 1'b1);

    // Reset mid-pulse; the interrupted frame is discarded by the monitor.
    next_frame();
    wait_cnt(300); rst = 1'b1;
    tick(); rst = 1'b0;
    push_frame(0, 0, 0, 0, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b0);
    next_frame(); push_frame(1000, 1000, 1000, 1000, 1'b1);
    next_frame();
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL monitor did not close the run");
    $fatal(1, "monitor stalled");
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cnt=%0d", tb_cnt);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
